// File: rtl/lsu_mem_port_if.sv
// Core-side request/response and memory data-port signals of the load/store unit.
// slave = the LSU itself, master = the core plus memory environment that drives it.
interface lsu_mem_port_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_we;
  logic [3:0]        mem_wmask;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_we, mem_wmask, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_we, mem_wmask, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_port.sv
// RV32 load/store to word-memory adapter: lane masks, store shifting, load extension.
// Latency 2 cycles (3 if split via LSU_MISALIGN_SPLIT_EN, 1 on error); req_ready low while busy.
module lsu_mem_port #(
  parameter int ADDR_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  lsu_mem_port_if.slave  bus
);

`ifdef LSU_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, RESP = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, RESP = 2'd3} state_e;
`endif

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0]       lo_q, lo_d;
  logic              cross_q, cross_d;
`endif
  logic [ADDR_W-1:0] word0;
  logic              req_cross;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      2'b10:   size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

  // hi selects the second-word nibble of the 8-lane mask
  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off,
                                           input logic hi);
    logic [7:0] m;
    m = {4'b0000, size_mask(sz)} << off;
    lane_mask = hi ? m[7:4] : m[3:0];
  endfunction

  function automatic logic [31:0] lane_data(input logic [31:0] d, input logic [1:0] off,
                                            input logic hi);
    logic [63:0] s;
    s = {32'd0, d} << {off, 3'b000};
    lane_data = hi ? s[63:32] : s[31:0];
  endfunction

  function automatic logic [31:0] extract(input logic [63:0] d, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [31:0] s;
    s = 32'(d >> {off, 3'b000});
    case (f3)
      3'b000:  extract = {{24{s[7]}}, s[7:0]};
      3'b001:  extract = {{16{s[15]}}, s[15:0]};
      3'b100:  extract = {24'd0, s[7:0]};
      3'b101:  extract = {16'd0, s[15:0]};
      default: extract = s;
    endcase
  endfunction

  function automatic logic illegal(input logic [2:0] f3, input logic we);
    illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
              (f3[2] && we);
  endfunction

  assign word0     = {addr_q[ADDR_W-1:2], 2'b00};
  assign req_cross = |lane_mask(bus.req_funct3[1:0], bus.req_addr[1:0], 1'b1);

  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    funct3_d       = funct3_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    lo_d           = lo_q;
    cross_d        = cross_q;
`endif
    bus.req_ready  = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_wmask  = 4'b0000;
    bus.mem_addr   = '0;
    bus.mem_wdata  = 32'd0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          if (illegal(bus.req_funct3, bus.req_we)) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
            state_d     = RESP;
          end else begin
`ifdef LSU_MISALIGN_SPLIT_EN
            cross_d = req_cross;
            state_d = ACC0;
`else
            // without the split path a word-crossing access is rejected untouched
            if (req_cross) begin
              rsp_err_d   = 1'b1;
              rsp_rdata_d = 32'd0;
              state_d     = RESP;
            end else begin
              state_d = ACC0;
            end
`endif
          end
        end
      end
      ACC0: begin
        bus.mem_addr = word0;
        if (we_q) begin
          bus.mem_we    = 1'b1;
          bus.mem_wmask = lane_mask(funct3_q[1:0], addr_q[1:0], 1'b0);
          bus.mem_wdata = lane_data(wdata_q, addr_q[1:0], 1'b0);
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        lo_d = bus.mem_rdata;
        if (cross_q) begin
          state_d = ACC1;
        end else
`endif
        begin
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? 32'd0 : extract({32'd0, bus.mem_rdata}, addr_q[1:0], funct3_q);
          state_d     = RESP;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ACC1: begin
        bus.mem_addr = word0 + ADDR_W'(4);
        if (we_q) begin
          bus.mem_we    = 1'b1;
          bus.mem_wmask = lane_mask(funct3_q[1:0], addr_q[1:0], 1'b1);
          bus.mem_wdata = lane_data(wdata_q, addr_q[1:0], 1'b1);
        end
        rsp_err_d   = 1'b0;
        rsp_rdata_d = we_q ? 32'd0 : extract({bus.mem_rdata, lo_q}, addr_q[1:0], funct3_q);
        state_d     = RESP;
      end
`endif
      RESP: begin
        bus.rsp_valid = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      lo_q        <= 32'd0;
      cross_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      lo_q        <= lo_d;
      cross_q     <= cross_d;
`endif
    end
  end

  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a 64-word byte-masked memory model;
// split-access vectors are selected by LSU_MISALIGN_SPLIT_EN.
module tb_lsu_mem_port;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  lsu_mem_port_if #(.ADDR_W(32)) bus ();

  lsu_mem_port #(.ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_dat;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_dat;
    end else if (bus.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_wmask[b]) mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

  // per-cycle trace of the last request, index 1 = first cycle after accept
  logic [31:0] tr_addr  [1:8];
  logic [31:0] tr_wdata [1:8];
  logic [3:0]  tr_mask  [1:8];
  logic        tr_we    [1:8];
  int          lat;
  int          nwe;
  logic        rdy_at_rsp;
  logic [31:0] got_rd;
  logic        got_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] dat);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_dat = dat;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk); #1;
    // scramble the request fields: the block must work from its latched copy
    bus.req_valid = 1'b0; bus.req_we = ~we; bus.req_funct3 = 3'b111;
    bus.req_addr = 32'hDEAD_BEE0; bus.req_wdata = 32'h0;
    lat = 0; nwe = 0; rdy_at_rsp = 1'bx; got_rd = 'x; got_err = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      tr_addr[c] = bus.mem_addr; tr_wdata[c] = bus.mem_wdata;
      tr_mask[c] = bus.mem_wmask; tr_we[c] = bus.mem_we;
      if (bus.mem_we) nwe++;
      if (bus.rsp_valid) begin
        lat = c; rdy_at_rsp = bus.req_ready; got_rd = bus.rsp_rdata; got_err = bus.rsp_err;
        break;
      end
    end
  endtask

  task automatic idle_chk(input string tag, input logic [31:0] exp_rd, input logic exp_err);
    @(negedge clk);
    chk({tag, " ready_after"}, {31'd0, bus.req_ready}, 32'd1);
    chk({tag, " valid_pulse"}, {31'd0, bus.rsp_valid}, 32'd0);
    chk({tag, " rdata_hold"}, bus.rsp_rdata, exp_rd);
    chk({tag, " err_hold"}, {31'd0, bus.rsp_err}, {31'd0, exp_err});
  endtask

  logic [2:0]  ld_f3  [0:4] = '{3'b100, 3'b001, 3'b101, 3'b010, 3'b001};
  logic [31:0] ld_adr [0:4] = '{32'h13, 32'h12, 32'h10, 32'h10, 32'h11};
  logic [31:0] ld_exp [0:4] = '{32'h0000_0088, 32'hFFFF_8899, 32'h0000_AABB,
                                32'h8899_AABB, 32'hFFFF_99AA};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; pl_en = 1'b0; pl_idx = '0; pl_dat = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
    chk("rst mem_we",    {31'd0, bus.mem_we}, 32'd0);
    chk("rst mem_wmask", {28'd0, bus.mem_wmask}, 32'd0);
    chk("rst mem_addr",  bus.mem_addr, 32'd0);
    chk("rst mem_wdata", bus.mem_wdata, 32'd0);

    poke(6'd0, 32'h0000_00CD);
    poke(6'd3, 32'h0);
    poke(6'd4, 32'h8899_AABB);
    poke(6'd8, 32'h0);
    poke(6'd9, 32'h0);
    poke(6'd12, 32'h4433_2211);
    poke(6'd13, 32'h8877_6655);
    poke(6'd63, 32'hAB00_0000);
    @(negedge clk);
    rst_n = 1'b1;

    do_req(1'b0, 3'b000, 32'h11, 32'h0);
    chk("lb lat", lat, 2);
    chk("lb rdata", got_rd, 32'hFFFF_FFAA);
    chk("lb err", {31'd0, got_err}, 32'd0);
    chk("lb ready_in_rsp", {31'd0, rdy_at_rsp}, 32'd0);
    chk("lb acc0_addr", tr_addr[1], 32'h10);
    chk("lb no_write", nwe, 0);
    idle_chk("lb", 32'hFFFF_FFAA, 1'b0);

    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, ld_f3[i], ld_adr[i], 32'h0);
      chk($sformatf("ld%0d lat", i), lat, 2);
      chk($sformatf("ld%0d rdata", i), got_rd, ld_exp[i]);
      chk($sformatf("ld%0d err", i), {31'd0, got_err}, 32'd0);
    end

    do_req(1'b1, 3'b001, 32'h22, 32'h0000_1234);
    chk("sh lat", lat, 2);
    chk("sh we", {31'd0, tr_we[1]}, 32'd1);
    chk("sh mask", {28'd0, tr_mask[1]}, 32'hC);
    chk("sh wdata", tr_wdata[1], 32'h1234_0000);
    chk("sh addr", tr_addr[1], 32'h20);
    chk("sh writes", nwe, 1);
    chk("sh rdata", got_rd, 32'd0);
    chk("sh mem", mem[8], 32'h1234_0000);

    do_req(1'b1, 3'b000, 32'h21, 32'h0000_005A);
    chk("sb mask", {28'd0, tr_mask[1]}, 32'h2);
    chk("sb wdata", tr_wdata[1], 32'h0000_5A00);
    chk("sb mem", mem[8], 32'h1234_5A00);

    do_req(1'b0, 3'b011, 32'h40, 32'h0);
    chk("f3_011 lat", lat, 1);
    chk("f3_011 err", {31'd0, got_err}, 32'd1);
    chk("f3_011 rdata", got_rd, 32'd0);
    chk("f3_011 no_write", nwe, 0);
    idle_chk("f3_011", 32'd0, 1'b1);

    do_req(1'b1, 3'b100, 32'h20, 32'hFFFF_FFFF);
    chk("sbu err", {31'd0, got_err}, 32'd1);
    chk("sbu lat", lat, 1);
    chk("sbu mem", mem[8], 32'h1234_5A00);

`ifdef LSU_MISALIGN_SPLIT_EN
    do_req(1'b0, 3'b010, 32'h33, 32'h0);
    chk("lw33 lat", lat, 3);
    chk("lw33 addr0", tr_addr[1], 32'h30);
    chk("lw33 addr1", tr_addr[2], 32'h34);
    chk("lw33 rdata", got_rd, 32'h7766_5544);
    chk("lw33 err", {31'd0, got_err}, 32'd0);

    do_req(1'b1, 3'b010, 32'h0E, 32'hDDCC_BBAA);
    chk("sw0e lat", lat, 3);
    chk("sw0e addr0", tr_addr[1], 32'h0C);
    chk("sw0e mask0", {28'd0, tr_mask[1]}, 32'hC);
    chk("sw0e data0", tr_wdata[1], 32'hBBAA_0000);
    chk("sw0e addr1", tr_addr[2], 32'h10);
    chk("sw0e mask1", {28'd0, tr_mask[2]}, 32'h3);
    chk("sw0e data1", tr_wdata[2], 32'h0000_DDCC);
    chk("sw0e mem0c", mem[3], 32'hBBAA_0000);
    chk("sw0e mem10", mem[4], 32'h8899_DDCC);

    do_req(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0);
    chk("lhwrap addr1", tr_addr[2], 32'h0);
    chk("lhwrap rdata", got_rd, 32'hFFFF_CDAB);
`else
    do_req(1'b0, 3'b010, 32'h33, 32'h0);
    chk("lw33 lat", lat, 1);
    chk("lw33 err", {31'd0, got_err}, 32'd1);
    chk("lw33 rdata", got_rd, 32'd0);
    chk("lw33 mem_we_rsp", {31'd0, tr_we[1]}, 32'd0);

    do_req(1'b1, 3'b001, 32'h23, 32'hFFFF_FFFF);
    chk("sh23 err", {31'd0, got_err}, 32'd1);
    chk("sh23 no_write", nwe, 0);
    chk("sh23 mem", mem[8], 32'h1234_5A00);
`endif

    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h24; bus.req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid we_before", {31'd0, bus.mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid we_async", {31'd0, bus.mem_we}, 32'd0);
    chk("rstmid ready_async", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    chk("rstmid no_rsp", seen, 0);
    chk("rstmid ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rstmid mem", mem[9], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store requester that drives the data port (port 2) of the shared instruction/data memory on behalf of the core.
- Memory data port: word-addressed, byte-masked, synchronous write, asynchronous read.
- Turns RV32 byte, halfword and word loads/stores into word transactions:
  - generates write masks and shifts store data into the correct byte lanes;
  - extracts and sign- or zero-extends load data;
  - splits accesses that cross a word boundary into two transactions.
- Sits between the execute stage and the memory; the core stalls on req_ready.

Parameters:
- ADDR_W, 32, byte-address width; word index = addr[ADDR_W-1:2].

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  block can accept a request (state IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data (0 for stores and errors)
- rsp_err  out  1  qualifies rsp_valid: illegal funct3 or unsupported misalignment
- mem_we  out  1  memory write enable
- mem_wmask  out  4  byte-lane write mask
- mem_addr  out  ADDR_W  memory byte address, always word-aligned (low 2 bits 0)
- mem_wdata  out  32  lane-aligned write data
- mem_rdata  in  32  asynchronous read data for mem_addr

Behaviour:
- Clock/reset: one clock (clk); rst_n is asynchronous and active-low.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_wmask=0, mem_addr=0, mem_wdata=0.
- Handshake: request accepted on a rising edge with req_valid && req_ready. All request fields are latched; inputs are ignored until the block returns to IDLE.
- FSM:
  - IDLE: on accept, go to ACC0. If funct3 is illegal (011/110/111, or 100/101 with req_we=1), go to RESP with err=1.
  - ACC0: mem_addr = {addr[ADDR_W-1:2],2'b00}.
    - Store: mem_we=1 with the low mask.
    - Load: capture mem_rdata into the lo buffer at the edge.
    - If the access crosses a word boundary, go to ACC1; otherwise go to RESP.
  - ACC1: mem_addr = word0 + 4, modulo 2^ADDR_W (address wrap is legal). Store uses the high mask; load captures mem_rdata into the hi buffer. Then go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then go to IDLE.
- mem_we is decoded from the state and is 0 outside ACC0/ACC1, including when the request is a load.
- Lane arithmetic, with off = addr[1:0] and size mask = 0001/0011/1111:
  - 8-bit mask = size mask << off; low nibble is the ACC0 mask, high nibble is the ACC1 mask.
  - 64-bit store data = zero-extended wdata << 8*off; low word goes out in ACC0, high word in ACC1.
  - Load: {hi,lo} >> 8*off, then truncate to size and sign-extend (B/H) or zero-extend (BU/HU).
  - An access crosses a word boundary iff the high mask nibble is non-zero: H at off=3, or W at off≠0.
- Latency, measured from the accept edge:
  - non-crossing access: rsp_valid high in the 2nd cycle;
  - crossing access: rsp_valid high in the 3rd cycle;
  - error: rsp_valid high in the 1st cycle.
  - req_ready returns the cycle after rsp_valid.
- rsp_rdata and rsp_err hold their values until the next response. rsp_rdata=0 for stores.
- Reset mid-operation: rst_n low forces IDLE and mem_we=0 immediately, with no clock needed. A partially completed split store (ACC0 done, ACC1 not) is left as written; no response is issued.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: word-crossing accesses are split via ACC1 as described above.
- Undefined:
  - ACC1 is not built.
  - A word-crossing access goes IDLE→RESP with rsp_err=1 and rsp_rdata=0, and performs no memory access (mem_we never asserted).
  - Non-crossing misaligned accesses (e.g., LB at off=3, LH at off=1) still complete normally.

Test Plan:
- Memory word 0x10 = 0x8899AABB. LB at addr 0x11 -> rsp_rdata=0xFFFFFFAA, rsp_err=0, rsp_valid in the 2nd cycle after accept.
- Memory word 0x20 = 0x00000000. SH 0x1234 at 0x22 -> single ACC0 cycle with mem_we=1, mem_wmask=1100, mem_wdata=0x12340000; word 0x20 reads 0x12340000.
- With macro defined: words 0x30=0x44332211, 0x34=0x88776655. LW at 0x33 -> mem_addr 0x30 then 0x34; rsp_rdata=0x77665544, rsp_valid in the 3rd cycle.
- With macro defined: SW 0xDDCCBBAA at 0x0E -> ACC0 writes 0x0C with mask 1100 and data 0xBBAA0000; ACC1 writes 0x10 with mask 0011 and data 0x0000DDCC.
- Without macro: LW at 0x33 -> rsp_err=1, rsp_rdata=0, rsp_valid in the 1st cycle, no memory access. Separately, funct3=011 load -> rsp_err=1.
- Assert rst_n low during ACC0 of a store -> mem_we drops within the same cycle; req_ready=1 after release; no rsp_valid pulse.
